// File: rtl/breathe_pkg.sv
// Shared types and sizing helpers for the breathing-light sequencer.
package breathe_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_e;

    // Default full-on duty for the stock 5-bit PWM period.
    localparam int DUTY_MAX = 32;

    // Bits needed to hold values 0..n-1 (never less than one).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int duty_max(input int bits);
        return 1 << bits;
    endfunction

endpackage

// File: rtl/breathe_tick_gen.sv
// Tick prescaler: one-clk tick every DIV clocks, with DIV re-chosen only when the count wraps.
module breathe_tick_gen
    import breathe_pkg::*;
#(
    parameter int DIV_FAST = 2500,
    parameter int DIV_SLOW = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic speed_ctrl_i,
    output logic tick_o
);

    localparam int CW = cnt_w(imax(DIV_FAST, DIV_SLOW));

    logic [CW-1:0] div_cnt_q, div_cnt_d, div_last;
    logic          fast_q, fast_d;

    assign div_last = fast_q ? CW'(DIV_FAST - 1) : CW'(DIV_SLOW - 1);
    assign tick_o   = !clr_i && (div_cnt_q == div_last);

    // While cleared the counter sits at a wrap point, so the speed keeps tracking the switch.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        fast_d    = fast_q;
        if (clr_i || tick_o) begin
            div_cnt_d = '0;
            fast_d    = speed_ctrl_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            fast_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            fast_q    <= fast_d;
        end
    end

endmodule

// File: rtl/breathe_sequencer.sv
// Breathing-light controller: ramps a PWM duty up, holds, ramps down, holds, and
// steers it to one channel at a time (chase) or all channels together (unison).
module breathe_sequencer
    import breathe_pkg::*;
#(
    parameter int CH_N       = 4,
    parameter int PWM_BITS   = 5,
    parameter int DIV_FAST   = 2500,
    parameter int DIV_SLOW   = 5000,
    parameter int HOLD_STEPS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    speed_ctrl,
    input  logic                    chase_en,
    output logic [CH_N-1:0]         led_out,
    output logic [$clog2(CH_N)-1:0] active_ch,
    output logic                    busy,
    output logic                    cycle_done
);

    localparam int CH_W  = $clog2(CH_N);
    localparam int DW    = PWM_BITS + 1;
    localparam int HW    = cnt_w(HOLD_STEPS);
    localparam int D_MAX = duty_max(PWM_BITS);

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [DW-1:0]       duty_q;
    logic [HW-1:0]       hold_cnt_q;
    logic                chase_q;
    logic [CH_W-1:0]     active_ch_q;
    logic [CH_N-1:0]     led_q, led_d;

    logic tick, period_end, hold_last, run;
    logic breath_end, latch_chase;

    assign run        = enable && (state_q != IDLE);
    assign period_end = tick && (pwm_cnt_q == '1);
    assign hold_last  = (hold_cnt_q == HW'(HOLD_STEPS - 1));

    breathe_tick_gen #(
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) u_tick (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (!run),
        .speed_ctrl_i (speed_ctrl),
        .tick_o       (tick)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = UP;
                UP:      if (period_end && duty_q == DW'(D_MAX - 1)) state_d = HOLD_HI;
                HOLD_HI: if (period_end && hold_last)                state_d = DOWN;
                DOWN:    if (period_end && duty_q == DW'(1))         state_d = HOLD_LO;
                HOLD_LO: if (period_end && hold_last)                state_d = UP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        breath_end  = enable && (state_q == HOLD_LO) && period_end && hold_last;
        latch_chase = enable && ((state_q == IDLE) || breath_end);
        cycle_done  = breath_end && (!chase_q || active_ch_q == CH_W'(CH_N - 1));
    end

    // ---------------- PWM counter, duty ramp, hold counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            hold_cnt_q <= '0;
        end else if (!run) begin
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            hold_cnt_q <= '0;
        end else if (tick) begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (period_end) begin
                case (state_q)
                    UP:      duty_q <= duty_q + 1'b1;
                    DOWN:    duty_q <= duty_q - 1'b1;
                    default: duty_q <= duty_q;
                endcase
                hold_cnt_q <= ((state_q == HOLD_HI || state_q == HOLD_LO) && !hold_last)
                              ? hold_cnt_q + 1'b1 : '0;
            end
        end
    end

    // ---------------- channel pointer ----------------
    // Chase mode is only re-read between breaths; active_ch survives an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chase_q     <= 1'b0;
            active_ch_q <= '0;
        end else begin
            if (latch_chase)
                chase_q <= chase_en;
            if (breath_end) begin
                if (!chase_q || active_ch_q == CH_W'(CH_N - 1))
                    active_ch_q <= '0;
                else
                    active_ch_q <= active_ch_q + 1'b1;
            end
        end
    end

    // ---------------- output register ----------------
    for (genvar i = 0; i < CH_N; i++) begin : g_ch
        assign led_d[i] = enable
                       && ({1'b0, pwm_cnt_q} < duty_q)
                       && (!chase_q || active_ch_q == CH_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_q <= '0;
        else        led_q <= led_d;
    end

    assign led_out   = led_q;
    assign active_ch = active_ch_q;

endmodule

// File: tb/tb_breathe_sequencer.sv
// Scoreboarded directed bench for breathe_sequencer (CH_N=3, PWM_BITS=2, 8-clk fast period).
`timescale 1ns/1ps
module tb_breathe_sequencer;

    localparam int CH_N = 3, PWM_BITS = 2, DIV_FAST = 2, DIV_SLOW = 4, HOLD_STEPS = 2;

    logic            clk = 1'b0, rst_n = 1'b1, enable = 1'b0, speed_ctrl = 1'b1, chase_en = 1'b1;
    logic [CH_N-1:0] led_out;
    logic [1:0]      active_ch;
    logic            busy, cycle_done;

    breathe_sequencer #(
        .CH_N(CH_N), .PWM_BITS(PWM_BITS), .DIV_FAST(DIV_FAST),
        .DIV_SLOW(DIV_SLOW), .HOLD_STEPS(HOLD_STEPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .speed_ctrl(speed_ctrl),
        .chase_en(chase_en), .led_out(led_out), .active_ch(active_ch),
        .busy(busy), .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {K_LED, K_ACT, K_BUSY} kind_e;
    typedef struct {
        int    at;
        kind_e kind;
        int    val;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   n_vec = 0, n_bad = 0;
    int   base = 0;

    function automatic void check(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    // Expected values are keyed by clock count relative to the first UP cycle.
    function automatic void exp_at(input int t, input kind_e k, input int v, input string nm);
        exp_t e;
        int   i;
        e = '{base + t, k, v, nm};
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].at > e.at) i--;
        exp_q.insert(i, e);
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e = exp_q.pop_front();
            if (e.at < cyc)
                check({e.name, " missed"}, cyc, e.at);
            else begin
                case (e.kind)
                    K_LED:   check(e.name, int'(led_out), e.val);
                    K_ACT:   check(e.name, int'(active_ch), e.val);
                    default: check(e.name, int'(busy), e.val);
                endcase
            end
        end
        if (cycle_done) begin
            if (done_q.size() == 0) check("cycle_done unexpected", cyc, -1);
            else                    check("cycle_done time", cyc, done_q.pop_front());
        end
    end

    task automatic wait_t(input int t);
        while (cyc < base + t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        base   = cyc + 1;
        exp_at(0, K_LED, 0, "rst led_out");
        exp_at(0, K_BUSY, 0, "rst busy");
        exp_at(0, K_ACT, 0, "rst active_ch");
        repeat (2) @(negedge clk);
    endtask

    // Called on a negedge; the next posedge enters UP, which becomes t=0.
    task automatic start(input logic spd, input logic ch);
        speed_ctrl = spd;
        chase_en   = ch;
        rst_n      = 1'b1;
        enable     = 1'b1;
        base       = cyc + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted summary");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;

        // 1+2: chase, fast; three breaths around ch0 -> ch1 -> ch2 -> ch0
        do_reset();
        start(1'b1, 1'b1);
        exp_at(0,   K_BUSY, 1,     "t1 busy");
        exp_at(1,   K_LED,  3'b000, "t1 led@1");
        exp_at(9,   K_LED,  3'b001, "t1 led@9");
        exp_at(11,  K_LED,  3'b000, "t1 led@11");
        exp_at(25,  K_LED,  3'b001, "t1 led@25");
        exp_at(31,  K_LED,  3'b000, "t1 led@31");
        exp_at(33,  K_LED,  3'b001, "t1 holdhi@33");
        exp_at(47,  K_LED,  3'b001, "t1 holdhi@47");
        exp_at(55,  K_LED,  3'b001, "t1 down@55");
        exp_at(63,  K_LED,  3'b000, "t1 down@63");
        exp_at(81,  K_LED,  3'b000, "t1 holdlo@81");
        exp_at(95,  K_ACT,  0,     "t1 act@95");
        exp_at(96,  K_ACT,  1,     "t1 act@96");
        exp_at(105, K_LED,  3'b010, "t2 led@105");
        exp_at(192, K_ACT,  2,     "t2 act@192");
        exp_at(201, K_LED,  3'b100, "t2 led@201");
        exp_at(288, K_ACT,  0,     "t2 act@288");
        exp_at(297, K_LED,  3'b001, "t2 led@297");
        done_q.push_back(base + 287);
        wait_t(300);

        // 3: unison; chase_en raised mid-breath only takes effect at the next breath
        do_reset();
        start(1'b1, 1'b0);
        exp_at(9,   K_LED, 3'b111, "t3 led@9");
        exp_at(11,  K_LED, 3'b000, "t3 led@11");
        exp_at(33,  K_LED, 3'b111, "t3 holdhi@33");
        exp_at(40,  K_LED, 3'b111, "t3 holdhi@40");
        exp_at(47,  K_LED, 3'b111, "t3 holdhi@47");
        exp_at(96,  K_ACT, 0,      "t3 act@96");
        exp_at(145, K_LED, 3'b111, "t3 latched@145");
        exp_at(201, K_LED, 3'b001, "t3 chase@201");
        exp_at(288, K_ACT, 1,      "t3 act@288");
        exp_at(297, K_LED, 3'b010, "t3 led@297");
        done_q.push_back(base + 95);
        done_q.push_back(base + 191);
        wait_t(140);
        chase_en = 1'b1;
        wait_t(300);

        // 4: speed 1->0 in the first tick: ticks at 1,5,9,... so periods end at 13+16k
        do_reset();
        start(1'b1, 1'b0);
        exp_at(15,  K_LED,  3'b111, "t4 led@15");
        exp_at(19,  K_LED,  3'b000, "t4 led@19");
        exp_at(190, K_BUSY, 1,      "t4 busy@190");
        done_q.push_back(base + 189);
        done_q.push_back(base + 381);
        wait_t(0);
        speed_ctrl = 1'b0;
        wait_t(390);

        // 5: abort in ch1's DOWN at duty=2, then resume on ch1 from duty 0
        do_reset();
        start(1'b1, 1'b1);
        exp_at(161, K_LED,  3'b010, "t5 led@161");
        exp_at(162, K_LED,  3'b010, "t5 led@162");
        exp_at(163, K_BUSY, 0,      "t5 abort busy");
        exp_at(163, K_LED,  3'b000, "t5 abort led");
        exp_at(164, K_LED,  3'b000, "t5 abort led+1");
        exp_at(164, K_ACT,  1,      "t5 abort act");
        wait_t(162);
        enable = 1'b0;
        wait_t(170);
        start(1'b1, 1'b1);
        exp_at(0,  K_BUSY, 1,      "t5 restart busy");
        exp_at(0,  K_ACT,  1,      "t5 restart act");
        exp_at(1,  K_LED,  3'b000, "t5 restart led@1");
        exp_at(9,  K_LED,  3'b010, "t5 restart led@9");
        exp_at(25, K_LED,  3'b010, "t5 restart led@25");
        exp_at(31, K_LED,  3'b000, "t5 restart led@31");
        exp_at(96, K_ACT,  2,      "t5 restart act@96");
        wait_t(100);

        // 6: asynchronous reset in ch1's HOLD_HI
        do_reset();
        start(1'b1, 1'b1);
        exp_at(105, K_LED, 3'b010, "t6 led@105");
        exp_at(130, K_LED, 3'b010, "t6 holdhi@130");
        wait_t(130);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async led_out",    int'(led_out),    0);
        check("t6 async busy",       int'(busy),       0);
        check("t6 async active_ch",  int'(active_ch),  0);
        check("t6 async cycle_done", int'(cycle_done), 0);
        repeat (2) @(negedge clk);
        start(1'b1, 1'b1);
        exp_at(0,  K_BUSY, 1,      "t6 restart busy");
        exp_at(9,  K_LED,  3'b001, "t6 restart led@9");
        exp_at(20, K_ACT,  0,      "t6 restart act");
        wait_t(20);

        @(negedge clk);
        check("pending expectations", exp_q.size(), 0);
        check("pending cycle_done",   done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
